// File: rtl/execute.sv
// RV32I execute stage: ALU, branch/jump resolution and the registered hand-off to
// the memory stage, plus the redirect and flush requests sent back to fetch/decode.
module execute #(
  parameter int XLEN            = 32,
  parameter int ALU_WIDTH       = 14,
  parameter int OPCODE_WIDTH    = 11,
  parameter int EXCEPTION_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [XLEN-1:0]            decode_pc,
  input  logic [XLEN-1:0]            decode_rs1_data,
  input  logic [XLEN-1:0]            decode_rs2_data,
  input  logic [4:0]                 decode_r_rd,
  input  logic [XLEN-1:0]            decode_imm,
  input  logic [2:0]                 decode_funct3,
  input  logic [ALU_WIDTH-1:0]       decode_alu_type,
  input  logic [OPCODE_WIDTH-1:0]    decode_opcode_type,
  input  logic [EXCEPTION_WIDTH-1:0] decode_exception,
  output logic [XLEN-1:0]            execute_result,
  output logic [XLEN-1:0]            execute_rs2_data,
  output logic [4:0]                 execute_r_rd,
  output logic                       execute_rd_wr_en,
  output logic [2:0]                 execute_funct3,
  output logic [OPCODE_WIDTH-1:0]    execute_opcode_type,
  output logic [EXCEPTION_WIDTH-1:0] execute_exception,
  output logic [XLEN-1:0]            execute_pc,
  output logic                       execute_change_pc,
  output logic [XLEN-1:0]            execute_next_pc,
  input  logic                       clk_en,
  output logic                       next_clk_en,
  input  logic                       stall,
  output logic                       next_stall,
  input  logic                       flush,
  output logic                       next_flush
);

  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3, ALU_XOR = 4,
                 ALU_OR = 5, ALU_AND = 6, ALU_SLL = 7, ALU_SRL = 8, ALU_SRA = 9,
                 ALU_EQ = 10, ALU_NEQ = 11, ALU_GE = 12, ALU_GEU = 13;
  localparam int OP_RTYPE = 0, OP_ITYPE = 1, OP_LOAD = 2, OP_STORE = 3, OP_BRANCH = 4,
                 OP_JAL = 5, OP_JALR = 6, OP_LUI = 7, OP_AUIPC = 8;
  localparam int EXC_MISALIGNED = 3;

  logic [XLEN-1:0]            op_b, alu_out, rs1_imm, pc_imm, target, result_d;
  logic [4:0]                 shamt;
  logic                       equal, signed_lt, unsigned_lt, branch_cond, taken;
  logic                       misaligned, writes_rd, has_exception;
  logic [EXCEPTION_WIDTH-1:0] exception_d;

  assign op_b = (decode_opcode_type[OP_RTYPE] | decode_opcode_type[OP_BRANCH]) ?
                decode_rs2_data : decode_imm;
  assign shamt       = op_b[4:0];
  assign equal       = decode_rs1_data == op_b;
  assign signed_lt   = $signed(decode_rs1_data) < $signed(op_b);
  assign unsigned_lt = decode_rs1_data < op_b;

  // NOTE: every variable driven in always_comb gets a default first so no path can infer a latch.
  always_comb begin
    alu_out = '0;
    case (1'b1)
      decode_alu_type[ALU_ADD]:  alu_out = decode_rs1_data + op_b;
      decode_alu_type[ALU_SUB]:  alu_out = decode_rs1_data - op_b;
      decode_alu_type[ALU_SLT]:  alu_out = XLEN'(signed_lt);
      decode_alu_type[ALU_SLTU]: alu_out = XLEN'(unsigned_lt);
      decode_alu_type[ALU_XOR]:  alu_out = decode_rs1_data ^ op_b;
      decode_alu_type[ALU_OR]:   alu_out = decode_rs1_data | op_b;
      decode_alu_type[ALU_AND]:  alu_out = decode_rs1_data & op_b;
      decode_alu_type[ALU_SLL]:  alu_out = decode_rs1_data << shamt;
      decode_alu_type[ALU_SRL]:  alu_out = decode_rs1_data >> shamt;
      decode_alu_type[ALU_SRA]:  alu_out = $signed(decode_rs1_data) >>> shamt;
      decode_alu_type[ALU_EQ]:   alu_out = XLEN'(equal);
      decode_alu_type[ALU_NEQ]:  alu_out = XLEN'(!equal);
      decode_alu_type[ALU_GE]:   alu_out = XLEN'(!signed_lt);
      decode_alu_type[ALU_GEU]:  alu_out = XLEN'(!unsigned_lt);
      default:                   alu_out = '0;
    endcase
  end

  always_comb begin
    branch_cond = 1'b0;
    case (decode_funct3)
      3'b000:  branch_cond = equal;
      3'b001:  branch_cond = !equal;
      3'b100:  branch_cond = signed_lt;
      3'b101:  branch_cond = !signed_lt;
      3'b110:  branch_cond = unsigned_lt;
      3'b111:  branch_cond = !unsigned_lt;
      default: branch_cond = 1'b0;
    endcase
  end

  assign rs1_imm = decode_rs1_data + decode_imm;
  assign pc_imm  = decode_pc + decode_imm;
  assign target  = decode_opcode_type[OP_JALR] ? {rs1_imm[XLEN-1:1], 1'b0} : pc_imm;
  assign taken   = (decode_opcode_type[OP_BRANCH] & branch_cond) |
                   decode_opcode_type[OP_JAL] | decode_opcode_type[OP_JALR];
  // Only target[1] matters: bit 0 is already cleared for jalr and always 0 for pc+imm.
  assign misaligned = taken & target[1];

  always_comb begin
    exception_d = decode_exception;
    exception_d[EXC_MISALIGNED] = decode_exception[EXC_MISALIGNED] | misaligned;
  end

  assign has_exception = |exception_d;
  assign writes_rd = decode_opcode_type[OP_RTYPE] | decode_opcode_type[OP_ITYPE] |
                     decode_opcode_type[OP_LOAD]  | decode_opcode_type[OP_JAL]   |
                     decode_opcode_type[OP_JALR]  | decode_opcode_type[OP_LUI]   |
                     decode_opcode_type[OP_AUIPC];

  always_comb begin
    result_d = alu_out;
    if (decode_opcode_type[OP_LUI])
      result_d = decode_imm;
    else if (decode_opcode_type[OP_AUIPC])
      result_d = pc_imm;
    else if (decode_opcode_type[OP_JAL] | decode_opcode_type[OP_JALR])
      result_d = decode_pc + XLEN'(4);
    else if (decode_opcode_type[OP_LOAD] | decode_opcode_type[OP_STORE])
      result_d = rs1_imm;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      execute_result      <= '0;
      execute_rs2_data    <= '0;
      execute_r_rd        <= '0;
      execute_rd_wr_en    <= 1'b0;
      execute_funct3      <= '0;
      execute_opcode_type <= '0;
      execute_exception   <= '0;
      execute_pc          <= '0;
      execute_change_pc   <= 1'b0;
      execute_next_pc     <= '0;
      next_clk_en         <= 1'b0;
    end else if (flush) begin
      next_clk_en       <= 1'b0;
      execute_change_pc <= 1'b0;
      execute_rd_wr_en  <= 1'b0;
    end else if (stall) begin
      execute_change_pc <= 1'b0;
    end else if (clk_en) begin
      execute_result      <= result_d;
      execute_rs2_data    <= decode_rs2_data;
      execute_r_rd        <= decode_r_rd;
      execute_rd_wr_en    <= writes_rd & (decode_r_rd != 5'd0) & ~has_exception;
      execute_funct3      <= decode_funct3;
      execute_opcode_type <= decode_opcode_type;
      execute_exception   <= exception_d;
      execute_pc          <= decode_pc;
      execute_change_pc   <= taken & ~has_exception;
      next_clk_en         <= 1'b1;
      // Target is recorded even when misaligned so the trap handler can see it.
      if (taken) execute_next_pc <= target;
    end else begin
      next_clk_en       <= 1'b0;
      execute_change_pc <= 1'b0;
      execute_rd_wr_en  <= 1'b0;
    end
  end

  assign next_stall = stall | (clk_en & stall);
  assign next_flush = flush | execute_change_pc;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: scoreboard of expected stage outputs
// plus directed stall, flush and asynchronous reset scenarios.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] decode_pc, decode_rs1_data, decode_rs2_data, decode_imm;
  logic [4:0]  decode_r_rd;
  logic [2:0]  decode_funct3;
  logic [13:0] decode_alu_type;
  logic [10:0] decode_opcode_type;
  logic [3:0]  decode_exception;
  logic [31:0] execute_result, execute_rs2_data, execute_pc, execute_next_pc;
  logic [4:0]  execute_r_rd;
  logic        execute_rd_wr_en, execute_change_pc;
  logic [2:0]  execute_funct3;
  logic [10:0] execute_opcode_type;
  logic [3:0]  execute_exception;
  logic        clk_en, next_clk_en, stall, next_stall, flush, next_flush;

  execute dut (
    .clk(clk), .rst(rst),
    .decode_pc(decode_pc), .decode_rs1_data(decode_rs1_data),
    .decode_rs2_data(decode_rs2_data), .decode_r_rd(decode_r_rd),
    .decode_imm(decode_imm), .decode_funct3(decode_funct3),
    .decode_alu_type(decode_alu_type), .decode_opcode_type(decode_opcode_type),
    .decode_exception(decode_exception),
    .execute_result(execute_result), .execute_rs2_data(execute_rs2_data),
    .execute_r_rd(execute_r_rd), .execute_rd_wr_en(execute_rd_wr_en),
    .execute_funct3(execute_funct3), .execute_opcode_type(execute_opcode_type),
    .execute_exception(execute_exception), .execute_pc(execute_pc),
    .execute_change_pc(execute_change_pc), .execute_next_pc(execute_next_pc),
    .clk_en(clk_en), .next_clk_en(next_clk_en),
    .stall(stall), .next_stall(next_stall),
    .flush(flush), .next_flush(next_flush)
  );

  always #5 clk = ~clk;

  localparam int RTYPE = 0, ITYPE = 1, LOAD = 2, STORE = 3, BRANCH = 4, JAL = 5,
                 JALR = 6, LUI = 7, AUIPC = 8;
  localparam int ADD = 0, SRA = 9, SLT = 2, GEU = 13, EQ = 10, NEQ = 11;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wr;
    logic [3:0]  exc;
    logic        chg;
    logic [31:0] npc;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [10:0] op;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return 32'($signed(a) < $signed(b));
      3:  return 32'(a < b);
      4:  return a ^ b;
      5:  return a | b;
      6:  return a & b;
      7:  return a << b[4:0];
      8:  return a >> b[4:0];
      9:  return $signed(a) >>> b[4:0];
      10: return 32'(a == b);
      11: return 32'(a != b);
      12: return 32'($signed(a) >= $signed(b));
      default: return 32'(a >= b);
    endcase
  endfunction

  task automatic drive(input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] rd,
                       input logic [2:0] f3, input int alu, input int op, input logic [3:0] exc_in);
    decode_pc          = pc;
    decode_rs1_data    = rs1;
    decode_rs2_data    = rs2;
    decode_imm         = imm;
    decode_r_rd        = rd;
    decode_funct3      = f3;
    decode_alu_type    = 14'(1) << alu;
    decode_opcode_type = 11'(1) << op;
    decode_exception   = exc_in;
  endtask

  task automatic check_out();
    exp_t e;
    check("valid", 32'(next_clk_en), 1);
    check("sb_depth", 32'(sb.size()), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("result", execute_result, e.result);
      check("r_rd", 32'(execute_r_rd), 32'(e.rd));
      check("rd_wr_en", 32'(execute_rd_wr_en), 32'(e.wr));
      check("exception", 32'(execute_exception), 32'(e.exc));
      check("change_pc", 32'(execute_change_pc), 32'(e.chg));
      check("next_pc", execute_next_pc, e.npc);
      check("next_flush", 32'(next_flush), 32'(e.chg));
      check("rs2_data", execute_rs2_data, e.rs2);
      check("pc", execute_pc, e.pc);
      check("funct3", 32'(execute_funct3), 32'(e.f3));
      check("opcode", 32'(execute_opcode_type), 32'(e.op));
    end
  endtask

  // Present one instruction for one cycle and compare the stage output one edge later.
  task automatic issue(input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] rd,
                       input logic [2:0] f3, input int alu, input int op, input logic [3:0] exc_in,
                       input logic [31:0] res, input logic wr, input logic [3:0] exc,
                       input logic chg, input logic [31:0] npc);
    @(negedge clk);
    drive(pc, rs1, rs2, imm, rd, f3, alu, op, exc_in);
    clk_en = 1'b1;
    sb.push_back('{res, rd, wr, exc, chg, npc, rs2, pc, f3, 11'(1) << op});
    @(posedge clk); #1;
    check_out();
  endtask

  task automatic idle();
    @(negedge clk);
    clk_en = 1'b0;
    @(posedge clk); #1;
    check("bubble_valid", 32'(next_clk_en), 0);
    check("bubble_change_pc", 32'(execute_change_pc), 0);
    check("bubble_wr_en", 32'(execute_rd_wr_en), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    int          alu;
    logic [4:0]  rd;

    rst = 1'b0; clk_en = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, ADD, RTYPE, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", execute_result, 0);
    check("rst_valid", 32'(next_clk_en), 0);
    check("rst_change_pc", 32'(execute_change_pc), 0);
    check("rst_next_pc", execute_next_pc, 0);
    check("rst_wr_en", 32'(execute_rd_wr_en), 0);
    @(negedge clk) rst = 1'b1;
    idle();

    // Arithmetic, shifts and result-select paths.
    issue(32'h0, 32'h5, 32'hFFFF_FFFE, 32'h0, 5'd3, 3'd0, ADD, RTYPE, 4'h0,
          32'h3, 1'b1, 4'h0, 1'b0, 32'h0);
    issue(32'h4, 32'h8000_0000, 32'h0, 32'h4, 5'd5, 3'd5, SRA, ITYPE, 4'h0,
          32'hF800_0000, 1'b1, 4'h0, 1'b0, 32'h0);
    issue(32'h8, 32'h11, 32'h0, 32'h22, 5'd0, 3'd0, ADD, ITYPE, 4'h0,
          32'h33, 1'b0, 4'h0, 1'b0, 32'h0);
    issue(32'hC, 32'hA, 32'h0, 32'h5, 5'd4, 3'd0, ADD, ITYPE, 4'h1,
          32'hF, 1'b0, 4'h1, 1'b0, 32'h0);
    issue(32'h10, 32'h0, 32'h0, 32'h1234_5000, 5'd2, 3'd0, ADD, LUI, 4'h0,
          32'h1234_5000, 1'b1, 4'h0, 1'b0, 32'h0);
    issue(32'h100, 32'h0, 32'h0, 32'h1000, 5'd6, 3'd0, ADD, AUIPC, 4'h0,
          32'h1100, 1'b1, 4'h0, 1'b0, 32'h0);
    issue(32'h104, 32'h200, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd0, 3'd2, ADD, STORE, 4'h0,
          32'h1FC, 1'b0, 4'h0, 1'b0, 32'h0);
    issue(32'h108, 32'h300, 32'h0, 32'h4, 5'd7, 3'd2, ADD, LOAD, 4'h0,
          32'h304, 1'b1, 4'h0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      a   = $urandom;
      b   = (i % 4 == 0) ? a : $urandom;
      alu = $urandom_range(0, 13);
      rd  = 5'($urandom_range(1, 31));
      issue(32'h200 + 32'(i * 4), a, b, 32'h0, rd, 3'd0, alu, RTYPE, 4'h0,
            ref_alu(alu, a, b), 1'b1, 4'h0, 1'b0, 32'h0);
    end
    idle();

    // Branches and jumps.
    issue(32'h10, 32'h7, 32'h7, 32'h8, 5'd0, 3'b000, EQ, BRANCH, 4'h0,
          32'h1, 1'b0, 4'h0, 1'b1, 32'h18);
    idle();
    issue(32'h10, 32'h7, 32'h7, 32'h8, 5'd0, 3'b001, NEQ, BRANCH, 4'h0,
          32'h0, 1'b0, 4'h0, 1'b0, 32'h18);
    issue(32'h20, 32'h103, 32'h0, 32'h0, 5'd1, 3'd0, ADD, JALR, 4'h0,
          32'h24, 1'b0, 4'h8, 1'b0, 32'h102);
    issue(32'h20, 32'h101, 32'h0, 32'h0, 5'd1, 3'd0, ADD, JALR, 4'h0,
          32'h24, 1'b1, 4'h0, 1'b1, 32'h100);
    issue(32'h80, 32'hFFFF_FFFF, 32'h1, 32'h10, 5'd0, 3'b100, SLT, BRANCH, 4'h0,
          32'h1, 1'b0, 4'h0, 1'b1, 32'h90);
    issue(32'h80, 32'hFFFF_FFFF, 32'h1, 32'h20, 5'd0, 3'b111, GEU, BRANCH, 4'h0,
          32'h1, 1'b0, 4'h0, 1'b1, 32'hA0);
    idle();

    // Stall right after a taken JAL: outputs hold, the pulse is not repeated.
    issue(32'h40, 32'h0, 32'h0, 32'h20, 5'd1, 3'd0, ADD, JAL, 4'h0,
          32'h44, 1'b1, 4'h0, 1'b1, 32'h60);
    @(negedge clk);
    drive(32'h44, 32'h1, 32'h2, 32'h0, 5'd9, 3'd0, ADD, RTYPE, 4'h0);
    clk_en = 1'b1;
    stall  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("stall_change_pc", 32'(execute_change_pc), 0);
      check("stall_next_stall", 32'(next_stall), 1);
      check("stall_result", execute_result, 32'h44);
      check("stall_r_rd", 32'(execute_r_rd), 1);
      check("stall_valid", 32'(next_clk_en), 1);
      check("stall_next_pc", execute_next_pc, 32'h60);
    end
    @(negedge clk);
    stall = 1'b0;
    sb.push_back('{32'h3, 5'd9, 1'b1, 4'h0, 1'b0, 32'h60, 32'h2, 32'h44, 3'd0, 11'(1) << RTYPE});
    #1 check("release_next_stall", 32'(next_stall), 0);
    @(posedge clk); #1;
    check_out();

    // Flush coincident with a taken branch wins over capture.
    @(negedge clk);
    drive(32'h10, 32'h7, 32'h7, 32'h8, 5'd0, 3'b000, EQ, BRANCH, 4'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_valid", 32'(next_clk_en), 0);
    check("flush_change_pc", 32'(execute_change_pc), 0);
    check("flush_wr_en", 32'(execute_rd_wr_en), 0);
    check("flush_next_flush", 32'(next_flush), 1);
    @(negedge clk);
    flush = 1'b0;
    clk_en = 1'b0;

    // Asynchronous reset in the middle of a redirect pulse.
    issue(32'h200, 32'h0, 32'h0, 32'h40, 5'd3, 3'd0, ADD, JAL, 4'h0,
          32'h204, 1'b1, 4'h0, 1'b1, 32'h240);
    #2 rst = 1'b0;
    #1;
    check("arst_result", execute_result, 0);
    check("arst_change_pc", 32'(execute_change_pc), 0);
    check("arst_next_pc", execute_next_pc, 0);
    check("arst_valid", 32'(next_clk_en), 0);
    check("arst_wr_en", 32'(execute_rd_wr_en), 0);
    check("arst_r_rd", 32'(execute_r_rd), 0);
    check("arst_next_flush", 32'(next_flush), 0);
    @(negedge clk);
    clk_en = 1'b0;
    rst = 1'b1;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
